// File: rtl/potato1_datapath.sv
// potato1_datapath: execution-side partner of the Potato1 controller.
// Holds program memory, PC, tape pointer X and the tape. It executes the
// 8-bit command word, runs the PUT/GET byte handshakes and accepts a serially
// loaded program.
// Optional build macro: POTATO1_DP_STEPCOUNT_EN enables the StepCount
// accepted-command counter. When it is undefined, StepCount is tied to zero.
module potato1_datapath #(
   parameter int PC_WIDTH   = 5,
   parameter int X_WIDTH    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [7:0]            Command,
   output logic [3:0]            Instruction,
   output logic                  ZeroFlag,
   output logic                  IOWait,
   output logic [DATA_WIDTH-1:0] OutData,
   output logic                  OutValid,
   input  logic                  OutReady,
   input  logic [DATA_WIDTH-1:0] InData,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic                  LoadEn,
   input  logic                  LoadValid,
   input  logic [3:0]            LoadNibble,
   output logic [15:0]           StepCount
);

   localparam int unsigned PROG_DEPTH = 2 ** PC_WIDTH;
   localparam int unsigned TAPE_DEPTH = 2 ** X_WIDTH;

   localparam logic [PC_WIDTH-1:0]   PC_ONE   = PC_WIDTH'(1);
   localparam logic [X_WIDTH-1:0]    X_ONE    = X_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] CELL_ONE = DATA_WIDTH'(1);
   localparam logic [3:0]            HALT     = 4'b1111;

   typedef enum logic [1:0] {
      RUN,
      PUT_WAIT,
      GET_WAIT,
      RELEASE
   } state_t;

   state_t                state;
   logic [PC_WIDTH-1:0]   pc;
   logic [X_WIDTH-1:0]    x;
   logic [PC_WIDTH-1:0]   load_addr;
   logic [X_WIDTH-1:0]    target;
   logic [3:0]            prog [PROG_DEPTH];
   logic [DATA_WIDTH-1:0] tape [TAPE_DEPTH];

   logic [PC_WIDTH-1:0]   pc_next;
   logic [X_WIDTH-1:0]    x_next;
   logic [DATA_WIDTH-1:0] cell_cur;
   logic [DATA_WIDTH-1:0] cell_next;
   logic                  zero_run;
   logic                  zero_get;

   // Next PC/X/cell values for a RUN command; paired INC+DEC cancel out.
   always_comb begin
      cell_cur = tape[x];

      pc_next = pc;
      case (Command[1:0])
         2'b01:   pc_next = pc + PC_ONE;
         2'b10:   pc_next = pc - PC_ONE;
         default: pc_next = pc;
      endcase

      x_next = x;
      case (Command[3:2])
         2'b01:   x_next = x + X_ONE;
         2'b10:   x_next = x - X_ONE;
         default: x_next = x;
      endcase

      cell_next = cell_cur;
      case (Command[5:4])
         2'b01:   cell_next = cell_cur + CELL_ONE;
         2'b10:   cell_next = cell_cur - CELL_ONE;
         default: cell_next = cell_cur;
      endcase

      // The cell written this edge is not yet visible in tape[], so forward it
      // when X does not move.
      zero_run = (x_next == x) ? (cell_next == '0) : (tape[x_next] == '0);
      // The GET byte lands in the target cell, which may be the current cell.
      zero_get = (target == x) ? (InData == '0) : (cell_cur == '0);
   end

   // Program memory: written only in load mode and never reset.
   always_ff @(posedge Clock) begin
      if (LoadEn && LoadValid) begin
         prog[load_addr] <= LoadNibble;
      end
   end

   // Control FSM with registered outputs, tape and pointer state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= RUN;
         pc          <= '0;
         x           <= '0;
         load_addr   <= '0;
         target      <= '0;
         for (int unsigned i = 0; i < TAPE_DEPTH; i++) begin
            tape[X_WIDTH'(i)] <= '0;
         end
         Instruction <= HALT;
         ZeroFlag    <= 1'b1;
         IOWait      <= 1'b0;
         OutValid    <= 1'b0;
         OutData     <= '0;
         InReady     <= 1'b0;
      end else if (LoadEn) begin
         state       <= RUN;
         pc          <= '0;
         OutValid    <= 1'b0;
         InReady     <= 1'b0;
         IOWait      <= 1'b0;
         Instruction <= HALT;
         ZeroFlag    <= (cell_cur == '0);
         if (LoadValid) begin
            load_addr <= load_addr + PC_ONE;
         end
      end else begin
         load_addr <= '0;
         case (state)
            RUN: begin
               pc          <= pc_next;
               x           <= x_next;
               tape[x]     <= cell_next;
               Instruction <= prog[pc_next];
               ZeroFlag    <= zero_run;
               if (Command[6]) begin
                  // OutData takes the cell as it was before this command's A step.
                  OutData  <= cell_cur;
                  OutValid <= 1'b1;
                  IOWait   <= 1'b1;
                  state    <= PUT_WAIT;
               end else if (Command[7]) begin
                  target   <= x;
                  InReady  <= 1'b1;
                  IOWait   <= 1'b1;
                  state    <= GET_WAIT;
               end
            end
            PUT_WAIT: begin
               Instruction <= prog[pc];
               ZeroFlag    <= (cell_cur == '0);
               if (OutValid && OutReady) begin
                  OutValid <= 1'b0;
                  IOWait   <= 1'b0;
                  state    <= RELEASE;
               end
            end
            GET_WAIT: begin
               Instruction <= prog[pc];
               ZeroFlag    <= (cell_cur == '0);
               if (InValid) begin
                  tape[target] <= InData;
                  ZeroFlag     <= zero_get;
                  InReady      <= 1'b0;
                  IOWait       <= 1'b0;
                  state        <= RELEASE;
               end
            end
            RELEASE: begin
               Instruction <= prog[pc];
               ZeroFlag    <= (cell_cur == '0);
               state       <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

`ifdef POTATO1_DP_STEPCOUNT_EN
   logic [15:0] step_cnt;

   // Count nonzero commands accepted in RUN; load mode clears the count.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         step_cnt <= '0;
      end else if (LoadEn) begin
         step_cnt <= '0;
      end else if ((state == RUN) && (Command != '0)) begin
         step_cnt <= step_cnt + 16'd1;
      end
   end

   assign StepCount = step_cnt;
`else
   assign StepCount = '0;
`endif

endmodule
